// File: rtl/key_pulse_gen.sv
// key_pulse_gen: push-button debouncer feeding the lab D flip-flop.
// Synchronizes a raw key, debounces press and release with a shared
// counter, and emits a one-cycle ena_out per accepted press along with a
// debounced level and a toggle bit. Everything runs on the falling edge.
// Optional feature: define KEY_PULSE_REPEAT_EN to compile in auto-repeat
// while the key is held (first repeat after REPEAT_DELAY cycles, then
// every REPEAT_PERIOD cycles).
module key_pulse_gen #(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic key_in,
    output logic ena_out,
    output logic key_level,
    output logic tog_out
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ena;
    logic             r_level;
    logic             r_tog;
    logic             w_level_nxt;
    logic             w_accept;
    logic             w_rep_pulse;
    logic             w_ena_nxt;

    // Two-flop synchronizer; the only logic that touches key_in.
    always_ff @(negedge CLK) begin
        if (RST_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= key_in;
            r_s2 <= r_s1;
        end
    end

    // Debounce FSM next-state: a press or release is accepted only after
    // DEBOUNCE_CYCLES+1 consecutive agreeing samples; any disagreement
    // falls back to the previous stable state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_s2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r_s2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = HELD;
                    w_level_nxt = 1'b1;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!r_s2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (r_s2) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef KEY_PULSE_REPEAT_EN
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;
    localparam logic [RC_W-1:0] LP_RC_DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] LP_RC_PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

    logic [RC_W-1:0] r_rc;
    logic [RC_W-1:0] w_rc_nxt;
    logic            r_rc_period;
    logic            w_rc_period_nxt;
    logic [RC_W-1:0] w_rc_last;

    // Repeat timer: counts only while held and stable; any other state,
    // including a bounce into RELEASE_WAIT, clears it back to the delay phase.
    always_comb begin
        w_rc_nxt        = '0;
        w_rc_period_nxt = 1'b0;
        w_rep_pulse     = 1'b0;
        w_rc_last       = r_rc_period ? LP_RC_PERIOD_LAST : LP_RC_DELAY_LAST;
        if (r_state == HELD && r_s2) begin
            if (r_rc == w_rc_last) begin
                w_rep_pulse     = 1'b1;
                w_rc_period_nxt = 1'b1;
            end else begin
                w_rc_nxt        = r_rc + RC_W'(1);
                w_rc_period_nxt = r_rc_period;
            end
        end
    end

    // Repeat timer registers.
    always_ff @(negedge CLK) begin
        if (RST_n) begin
            r_rc        <= '0;
            r_rc_period <= 1'b0;
        end else begin
            r_rc        <= w_rc_nxt;
            r_rc_period <= w_rc_period_nxt;
        end
    end
`else
    logic w_unused_repeat;
    assign w_unused_repeat = (REPEAT_DELAY > REPEAT_PERIOD);
    assign w_rep_pulse     = 1'b0;
`endif

    assign w_ena_nxt = w_accept | w_rep_pulse;

    // FSM state, counter and registered outputs; reset wins over every transition.
    always_ff @(negedge CLK) begin
        if (RST_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ena   <= 1'b0;
            r_level <= 1'b0;
            r_tog   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ena   <= w_ena_nxt;
            r_level <= w_level_nxt;
            r_tog   <= r_tog ^ w_ena_nxt;
        end
    end

    assign ena_out   = r_ena;
    assign key_level = r_level;
    assign tog_out   = r_tog;

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: randomized and directed bench for key_pulse_gen.
// The reference model tracks the synchronized key and counts runs of
// samples that disagree with the current debounced level.
module tb_key_pulse_gen;

    localparam int N  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic CLK = 1'b0;
    logic RST_n;
    logic key_in;
    logic ena_out;
    logic key_level;
    logic tog_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic m_s1, m_s2, m_level, m_ena, m_tog;
    int   m_run;
`ifdef KEY_PULSE_REPEAT_EN
    int   m_age;
`endif

    int pulse_cnt;
    int first_edge;

    key_pulse_gen #(
        .CNT_W(8),
        .DEBOUNCE_CYCLES(N),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .CLK(CLK),
        .RST_n(RST_n),
        .key_in(key_in),
        .ena_out(ena_out),
        .key_level(key_level),
        .tog_out(tog_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, $signed(obs), $signed(exp), $time);
        end
    endtask

    // Reference model, advanced once per falling edge with the inputs sampled there.
    task automatic model_step(input logic rst, input logic k);
        logic seen;
        logic pulse;
        logic holding;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_ena = 0; m_tog = 0;
`ifdef KEY_PULSE_REPEAT_EN
            m_age = 0;
`endif
            return;
        end
        seen    = m_s2;
        m_s2    = m_s1;
        m_s1    = k;
        pulse   = 1'b0;
        holding = m_level && (m_run == 0);
        if (seen != m_level) begin
            m_run++;
            if (m_run == N + 1) begin
                m_level = seen;
                m_run   = 0;
                if (seen) pulse = 1'b1;
            end
        end else begin
            m_run = 0;
        end
`ifdef KEY_PULSE_REPEAT_EN
        if (holding && seen) begin
            m_age++;
            if (m_age >= RD && ((m_age - RD) % RP) == 0) pulse = 1'b1;
        end else begin
            m_age = 0;
        end
`else
        if (holding && 1'b0) pulse = 1'b1;
`endif
        m_ena = pulse;
        if (pulse) m_tog = ~m_tog;
    endtask

    // One falling edge: drive inputs, advance model, compare all outputs.
    task automatic cycle(input logic rst, input logic k);
        RST_n  = rst;
        key_in = k;
        @(negedge CLK);
        model_step(rst, k);
        #2;
        chk("ena_out", ena_out, m_ena);
        chk("key_level", key_level, m_level);
        chk("tog_out", tog_out, m_tog);
        if (ena_out) pulse_cnt++;
    endtask

    initial begin
        int lvl, len, total, exp_hold;
        logic k;
        RST_n  = 1'b1;
        key_in = 1'b1;

        // Reset held for two edges with the key pressed.
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        chk("rst_ena", ena_out, 0);
        chk("rst_level", key_level, 0);
        chk("rst_tog", tog_out, 0);

        // Clean press straight out of reset: edge 0 is the first sample.
        pulse_cnt = 0; first_edge = -1;
        for (int e = 0; e < 12; e++) begin
            cycle(1'b0, 1'b1);
            if (ena_out && first_edge < 0) first_edge = e;
            if (e == 7) chk("press_ena_drop", ena_out, 0);
        end
        chk("press_first_edge", first_edge, 6);
        chk("press_pulses", pulse_cnt, 1);
        chk("press_tog", tog_out, 1);

        // Release: level drops at edge N+2, no pulse.
        pulse_cnt = 0; first_edge = -1;
        for (int e = 0; e < 10; e++) begin
            cycle(1'b0, 1'b0);
            if (!key_level && first_edge < 0) first_edge = e;
        end
        chk("release_edge", first_edge, 6);
        chk("release_pulses", pulse_cnt, 0);

        // Reset at edge 4 of a press discards the count.
        pulse_cnt = 0;
        for (int e = 0; e < 4; e++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        for (int e = 0; e < 6; e++) cycle(1'b0, 1'b0);
        chk("midrst_pulses", pulse_cnt, 0);
        chk("midrst_tog", tog_out, 0);
        chk("midrst_level", key_level, 0);

        // Bouncing press: 1,1,1,0 then steady high; accept 6 edges after the final rise.
        pulse_cnt = 0; first_edge = -1;
        for (int e = 0; e < 16; e++) begin
            cycle(1'b0, (e == 3) ? 1'b0 : 1'b1);
            if (ena_out && first_edge < 0) first_edge = e;
        end
        chk("bounce_first_rel", first_edge - 4, 6);
        chk("bounce_pulses", pulse_cnt, 1);
        chk("bounce_tog", tog_out, 1);
        for (int e = 0; e < 10; e++) cycle(1'b0, 1'b0);

        // Long hold of 40 edges.
`ifdef KEY_PULSE_REPEAT_EN
        exp_hold = 6;
`else
        exp_hold = 1;
`endif
        pulse_cnt = 0;
        for (int e = 0; e < 40; e++) cycle(1'b0, 1'b1);
        chk("hold_pulses", pulse_cnt, exp_hold);
        chk("hold_tog", tog_out, (exp_hold % 2 == 1) ? 0 : 1);
        for (int e = 0; e < 12; e++) cycle(1'b0, 1'b0);

        // Random segments with bounce glitches and occasional resets.
        total = 0;
        while (total < 3000) begin
            lvl = $urandom_range(0, 1);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                k = lvl[0];
                if ($urandom_range(0, 9) == 0) k = ~k;
                cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, k);
            end
            total += len;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
